// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Debounces four raw push-button levels (Start, Red, Green,
//               Blue) and turns each accepted press into a single-cycle
//               registered pulse for a downstream code detector. A Start
//               pulse wins over any colour pulse qualifying in the same
//               cycle; those colour pulses are dropped.
//               Optional macro BUTTON_SYNC_EN inserts a 2-flop synchroniser
//               in front of each channel's stability counter.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic Clk,
   input  logic Rst,
   input  logic StartBtn,
   input  logic RedBtn,
   input  logic GreenBtn,
   input  logic BlueBtn,
   output logic Start,
   output logic Red,
   output logic Green,
   output logic Blue
);

   // Channel index map: 0 = Start, 1 = Red, 2 = Green, 3 = Blue
   localparam int          c_NCH  = 4;
   localparam logic [15:0] c_LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic [c_NCH-1:0] w_raw;
   logic [c_NCH-1:0] w_sample;
   logic [c_NCH-1:0] w_qual;

   assign w_raw = {BlueBtn, GreenBtn, RedBtn, StartBtn};

`ifdef BUTTON_SYNC_EN
   logic [c_NCH-1:0] r_sync1;
   logic [c_NCH-1:0] r_sync2;

   // Two-flop synchroniser bringing the asynchronous button levels into Clk
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   assign w_sample = r_sync2;
`else
   // Stimulus is already synchronous to Clk: feed the counters directly
   assign w_sample = w_raw;
`endif

   generate
      for (genvar g = 0; g < c_NCH; g++) begin : g_ch
         logic [15:0] r_cnt;
         logic        r_deb;
         logic        w_diff;
         logic        w_done;

         assign w_diff = (w_sample[g] != r_deb);
         // The counter only ever reaches DEBOUNCE_CYCLES-1; the next
         // differing cycle is the accepting one, so it never wraps.
         assign w_done = w_diff && (r_cnt == c_LAST);
         // Only a rising acceptance (0 -> 1) qualifies for a pulse
         assign w_qual[g] = w_done && w_sample[g];

         // Stability counter and debounced state for this channel
         always_ff @(posedge Clk or negedge Rst) begin
            if (!Rst) begin
               r_cnt <= '0;
               r_deb <= 1'b0;
            end else if (!w_diff) begin
               r_cnt <= '0;
            end else if (w_done) begin
               r_deb <= ~r_deb;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 16'd1;
            end
         end
      end
   endgenerate

   // Registered pulses; Start suppresses colour pulses of the same cycle
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         Start <= 1'b0;
         Red   <= 1'b0;
         Green <= 1'b0;
         Blue  <= 1'b0;
      end else begin
         Start <= w_qual[0];
         Red   <= w_qual[1] & ~w_qual[0];
         Green <= w_qual[2] & ~w_qual[0];
         Blue  <= w_qual[3] & ~w_qual[0];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner with
//               DEBOUNCE_CYCLES=4. A run-length model predicts every output
//               each cycle; directed scenarios pin pulse counts and latency
//               with hand-computed literals. Honours BUTTON_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

   localparam int N = 4;
`ifdef BUTTON_SYNC_EN
   localparam int LAT = 5;   // pulse follows edge N+1
`else
   localparam int LAT = 3;   // pulse follows edge N-1
`endif

   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   logic start_b  = 1'b0;
   logic red_b    = 1'b0;
   logic green_b  = 1'b0;
   logic blue_b   = 1'b0;
   logic start_o;
   logic red_o;
   logic green_o;
   logic blue_o;

   int checks = 0;
   int errors = 0;
   int ecnt   = 0;

   always #5 clk = ~clk;

   button_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
      .Clk      (clk),
      .Rst      (rst_n),
      .StartBtn (start_b),
      .RedBtn   (red_b),
      .GreenBtn (green_b),
      .BlueBtn  (blue_b),
      .Start    (start_o),
      .Red      (red_o),
      .Green    (green_o),
      .Blue     (blue_o)
   );

   // ---------------- behavioural model ----------------
   // A level change is accepted once the observed sample has held the new
   // value for N consecutive edges; a rising acceptance yields a pulse.
   logic [3:0] m_d1, m_d2, m_acc, m_prev, m_s, m_q, m_raw;
   logic [3:0] exp_o = 4'b0;
   int         m_run [4];

   always @(posedge clk) begin
      ecnt++;
      if (!rst_n) begin
         m_d1 = '0; m_d2 = '0; m_acc = '0; m_prev = '0; exp_o = '0;
         for (int c = 0; c < 4; c++) m_run[c] = 0;
      end else begin
         m_raw = {blue_b, green_b, red_b, start_b};
`ifdef BUTTON_SYNC_EN
         m_s  = m_d2;
         m_d2 = m_d1;
         m_d1 = m_raw;
`else
         m_s  = m_raw;
`endif
         m_q = '0;
         for (int c = 0; c < 4; c++) begin
            if (m_s[c] == m_prev[c]) m_run[c]++;
            else                     m_run[c] = 1;
            if (m_s[c] != m_acc[c] && m_run[c] >= N) begin
               m_acc[c] = m_s[c];
               m_q[c]   = m_s[c];
            end
         end
         m_prev = m_s;
         exp_o  = {m_q[3:1] & {3{~m_q[0]}}, m_q[0]};
      end
   end

   // ---------------- compare + pulse bookkeeping ----------------
   int n_s = 0, n_r = 0, n_g = 0, n_b = 0;
   int l_s = -1, l_r = -1, l_g = -1, l_b = -1;
   logic [3:0] act, expv;

   always @(negedge clk) begin
      act  = {blue_o, green_o, red_o, start_o};
      expv = rst_n ? exp_o : 4'b0;
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL model_cmp edge %0d: got BGRS=%b expected %b", ecnt, act, expv);
      end
      if (start_o) begin n_s++; l_s = ecnt; end
      if (red_o)   begin n_r++; l_r = ecnt; end
      if (green_o) begin n_g++; l_g = ecnt; end
      if (blue_o)  begin n_b++; l_b = ecnt; end
   end

   task automatic chk(input string name, input int actual, input int required);
      checks++;
      if (actual != required) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, actual, required);
      end
   endtask

   task automatic clear_counts();
      n_s = 0; n_r = 0; n_g = 0; n_b = 0;
      l_s = -1; l_r = -1; l_g = -1; l_b = -1;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      start_b = 0; red_b = 0; green_b = 0; blue_b = 0;
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
      clear_counts();
   endtask

   int e0;

   initial begin
      // Reset state
      step(3);
      chk("reset_outputs", int'({blue_o, green_o, red_o, start_o}), 0);
      rst_n = 1'b1;
      step(1);
      clear_counts();

      // Clean press held 20 cycles, then released (release must not pulse)
      red_b = 1; e0 = ecnt + 1;
      step(20);
      red_b = 0;
      step(10);
      chk("clean_red_count", n_r, 1);
      chk("clean_red_edge", l_r, e0 + LAT);
      chk("clean_start_count", n_s, 0);
      chk("clean_green_count", n_g, 0);
      chk("clean_blue_count", n_b, 0);

      // Bounce 1,0,1,0 then held high
      do_reset();
      green_b = 1; step(1);
      green_b = 0; step(1);
      green_b = 1; step(1);
      green_b = 0; step(1);
      green_b = 1; e0 = ecnt + 1;
      step(15);
      chk("bounce_green_count", n_g, 1);
      chk("bounce_green_edge", l_g, e0 + LAT);

      // Start and Blue rise together
      do_reset();
      start_b = 1; blue_b = 1; e0 = ecnt + 1;
      step(15);
      chk("collide_start_count", n_s, 1);
      chk("collide_start_edge", l_s, e0 + LAT);
      chk("collide_blue_count", n_b, 0);

      // Red and Blue form one symbol
      do_reset();
      red_b = 1; blue_b = 1; e0 = ecnt + 1;
      step(15);
      chk("symbol_red_count", n_r, 1);
      chk("symbol_blue_count", n_b, 1);
      chk("symbol_same_edge", l_b, l_r);
      chk("symbol_red_edge", l_r, e0 + LAT);
      chk("symbol_green_count", n_g, 0);

      // Reset asserted mid-count with the button held through release
      do_reset();
      red_b = 1;
      step(3);
      rst_n = 1'b0;
      step(2);
      chk("midreset_no_pulse", n_r, 0);
      rst_n = 1'b1; e0 = ecnt + 1;
      step(12);
      chk("midreset_red_count", n_r, 1);
      chk("midreset_red_edge", l_r, e0 + LAT);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
